// File: rtl/seq_detect_param_if.sv
// Serial detector bus: bit/strobe/release inputs and registered status outputs.
interface seq_detect_param_if #(
   parameter int unsigned PAT_LEN = 3,
   parameter int unsigned CNT_W   = 8
);
   localparam int unsigned FILL_W = $clog2(PAT_LEN + 1);

   logic              in;
   logic              next;
   logic              clear_lock;
   logic [1:0]        state_display;
   logic [FILL_W-1:0] fill;
   logic              out;
   logic [CNT_W-1:0]  match_cnt;
   logic              locked;

   modport master (
      output in, next, clear_lock,
      input  state_display, fill, out, match_cnt, locked
   );

   modport slave (
      input  in, next, clear_lock,
      output state_display, fill, out, match_cnt, locked
   );
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector with match/lock patterns, overlap
// mode, sticky lock with explicit release, and a saturating match counter.
module seq_detect_param #(
   parameter int unsigned PAT_LEN   = 3,
   parameter logic [7:0]  MATCH_PAT = 8'b010,
   parameter logic [7:0]  LOCK_PAT  = 8'b111,
   parameter bit          OVERLAP   = 1'b1,
   parameter int unsigned CNT_W     = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   seq_detect_param_if.slave   bus
);
   localparam int unsigned FW = $clog2(PAT_LEN + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      RUN    = 2'd2,
      LOCKED = 2'd3
   } state_t;

   state_t               state_q, state_nxt;
   logic [PAT_LEN-1:0]   window_q, window_nxt;
   logic [FW-1:0]        fill_q, fill_nxt;
   logic                 out_q, out_nxt;
   logic                 locked_q, locked_nxt;
   logic [CNT_W-1:0]     cnt_q, cnt_nxt;

   logic                 accept_c;
   logic                 restart_c;
   logic [PAT_LEN-1:0]   shifted_c;
   logic [FW-1:0]        fill_inc_c;
   logic                 full_c;
   logic                 lock_hit_c;
   logic                 match_hit_c;

   // Shared evaluation terms on the post-shift window; clear_lock discards the bit.
   assign accept_c    = bus.next && (state_q != LOCKED) && !bus.clear_lock;
   assign restart_c   = !OVERLAP && out_q;
   assign shifted_c   = {window_q[PAT_LEN-2:0], bus.in};
   assign fill_inc_c  = (fill_q == FW'(PAT_LEN)) ? fill_q : fill_q + FW'(1);
   assign full_c      = (fill_inc_c == FW'(PAT_LEN));
   assign lock_hit_c  = full_c && (shifted_c == LOCK_PAT[PAT_LEN-1:0]);
   assign match_hit_c = full_c && !lock_hit_c && (shifted_c == MATCH_PAT[PAT_LEN-1:0]);

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         window_q <= '0;
         fill_q   <= '0;
         out_q    <= 1'b0;
         locked_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_nxt;
         window_q <= window_nxt;
         fill_q   <= fill_nxt;
         out_q    <= out_nxt;
         locked_q <= locked_nxt;
         cnt_q    <= cnt_nxt;
      end
   end

   // Next state, window and fill.
   always_comb begin
      state_nxt  = state_q;
      window_nxt = window_q;
      fill_nxt   = fill_q;
      if (bus.clear_lock) begin
         state_nxt  = IDLE;
         window_nxt = '0;
         fill_nxt   = '0;
      end else if (accept_c) begin
         if (restart_c) begin
            // Non-overlap: first bit after a match opens a fresh window.
            state_nxt  = FILL;
            window_nxt = {{(PAT_LEN-1){1'b0}}, bus.in};
            fill_nxt   = FW'(1);
         end else begin
            window_nxt = shifted_c;
            fill_nxt   = fill_inc_c;
            if (lock_hit_c)  state_nxt = LOCKED;
            else if (full_c) state_nxt = RUN;
            else             state_nxt = FILL;
         end
      end
   end

   // Next values of the match level, lock flag and saturating counter.
   always_comb begin
      out_nxt    = out_q;
      locked_nxt = locked_q;
      cnt_nxt    = cnt_q;
      if (bus.clear_lock) begin
         out_nxt    = 1'b0;
         locked_nxt = 1'b0;
      end else if (accept_c) begin
         out_nxt    = !restart_c && match_hit_c;
         locked_nxt = !restart_c && lock_hit_c;
         if (!restart_c && match_hit_c && (cnt_q != '1))
            cnt_nxt = cnt_q + CNT_W'(1);
      end
   end

   assign bus.state_display = state_q;
   assign bus.fill          = fill_q;
   assign bus.out           = out_q;
   assign bus.locked        = locked_q;
   assign bus.match_cnt     = cnt_q;
endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: default, non-overlap and 2-bit configs.
module tb_seq_detect_param;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_d [3];
   logic next_d [3];
   logic clr_d [3];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_detect_param_if #(.PAT_LEN(3), .CNT_W(8)) ifa ();
   seq_detect_param_if #(.PAT_LEN(3), .CNT_W(8)) ifb ();
   seq_detect_param_if #(.PAT_LEN(2), .CNT_W(2)) ifc ();

   assign ifa.in = in_d[0];  assign ifa.next = next_d[0];  assign ifa.clear_lock = clr_d[0];
   assign ifb.in = in_d[1];  assign ifb.next = next_d[1];  assign ifb.clear_lock = clr_d[1];
   assign ifc.in = in_d[2];  assign ifc.next = next_d[2];  assign ifc.clear_lock = clr_d[2];

   seq_detect_param #(.PAT_LEN(3), .MATCH_PAT(8'b010), .LOCK_PAT(8'b111),
                      .OVERLAP(1'b1), .CNT_W(8))
      dut_a (.clk(clk), .reset_n(rst_n), .bus(ifa));
   seq_detect_param #(.PAT_LEN(3), .MATCH_PAT(8'b010), .LOCK_PAT(8'b111),
                      .OVERLAP(1'b0), .CNT_W(8))
      dut_b (.clk(clk), .reset_n(rst_n), .bus(ifb));
   seq_detect_param #(.PAT_LEN(2), .MATCH_PAT(8'b11), .LOCK_PAT(8'b00),
                      .OVERLAP(1'b1), .CNT_W(2))
      dut_c (.clk(clk), .reset_n(rst_n), .bus(ifc));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One accepted bit on DUT d; outputs sampled 1 time unit after the edge.
   task automatic step(input int d, input logic b);
      in_d[d]   = b;
      next_d[d] = 1'b1;
      @(posedge clk); #1;
      next_d[d] = 1'b0;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         in_d[i] = 1'b0; next_d[i] = 1'b0; clr_d[i] = 1'b0;
      end
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;

      // Reset state
      chk("rst_state", ifa.state_display, 0);
      chk("rst_fill",  ifa.fill, 0);
      chk("rst_out",   ifa.out, 0);
      chk("rst_cnt",   ifa.match_cnt, 0);
      chk("rst_lock",  ifa.locked, 0);

      // Test 1: 0,1,0 fills then matches
      step(0, 0); chk("t1_fill1", ifa.fill, 1); chk("t1_st1", ifa.state_display, 1); chk("t1_out1", ifa.out, 0);
      step(0, 1); chk("t1_fill2", ifa.fill, 2); chk("t1_st2", ifa.state_display, 1); chk("t1_out2", ifa.out, 0);
      step(0, 0); chk("t1_fill3", ifa.fill, 3); chk("t1_st3", ifa.state_display, 2); chk("t1_out3", ifa.out, 1);
      chk("t1_cnt", ifa.match_cnt, 1);

      // Idle cycle holds everything
      @(posedge clk); #1;
      chk("hold_out", ifa.out, 1); chk("hold_fill", ifa.fill, 3);

      // Test 2: 0,1,1 no match; then 1 locks; further bits ignored
      step(0, 0); chk("t2_out_a", ifa.out, 0);
      step(0, 1); chk("t2_out_b", ifa.out, 0);
      step(0, 1); chk("t2_out_c", ifa.out, 0); chk("t2_nolock", ifa.locked, 0);
      step(0, 1);
      chk("t2_locked", ifa.locked, 1); chk("t2_st", ifa.state_display, 3); chk("t2_out", ifa.out, 0);
      step(0, 0); step(0, 1);
      chk("t2_frz_fill", ifa.fill, 3); chk("t2_frz_st", ifa.state_display, 3);
      chk("t2_frz_out", ifa.out, 0); chk("t2_frz_cnt", ifa.match_cnt, 1);

      // Test 3: clear_lock with next=1 discards the bit
      clr_d[0] = 1'b1; next_d[0] = 1'b1; in_d[0] = 1'b0;
      @(posedge clk); #1;
      clr_d[0] = 1'b0; next_d[0] = 1'b0;
      chk("t3_st", ifa.state_display, 0); chk("t3_fill", ifa.fill, 0);
      chk("t3_lock", ifa.locked, 0); chk("t3_cnt", ifa.match_cnt, 1);
      step(0, 0); step(0, 1); step(0, 0);
      chk("t3_out", ifa.out, 1); chk("t3_cnt2", ifa.match_cnt, 2);

      // Test 4: overlap vs non-overlap on 0,1,0,1,0
      pulse_reset();
      chk("t4_rst_cnt", ifa.match_cnt, 0);
      step(0, 0); step(0, 1); step(0, 0); chk("t4a_out3", ifa.out, 1);
      step(0, 1); chk("t4a_out4", ifa.out, 0);
      step(0, 0); chk("t4a_out5", ifa.out, 1); chk("t4a_cnt", ifa.match_cnt, 2);

      step(1, 0); step(1, 1); step(1, 0); chk("t4b_out3", ifb.out, 1);
      step(1, 1);
      chk("t4b_out4", ifb.out, 0); chk("t4b_fill4", ifb.fill, 1); chk("t4b_st4", ifb.state_display, 1);
      step(1, 0);
      chk("t4b_out5", ifb.out, 0); chk("t4b_fill5", ifb.fill, 2); chk("t4b_cnt", ifb.match_cnt, 1);

      // Test 6: 2-bit pattern, 2-bit counter saturates, 00 locks
      step(2, 1); chk("t6_cnt1", ifc.match_cnt, 0);
      step(2, 1); chk("t6_cnt2", ifc.match_cnt, 1); chk("t6_out2", ifc.out, 1);
      step(2, 1); chk("t6_cnt3", ifc.match_cnt, 2);
      step(2, 1); chk("t6_cnt4", ifc.match_cnt, 3);
      step(2, 1); chk("t6_cnt5", ifc.match_cnt, 3); chk("t6_out5", ifc.out, 1);
      step(2, 0); chk("t6_out6", ifc.out, 0); chk("t6_nolock", ifc.locked, 0);
      step(2, 0); chk("t6_lock", ifc.locked, 1); chk("t6_st", ifc.state_display, 3);

      // Test 5: next held three cycles (A window 010 from test 4), then reset
      in_d[0] = 1'b0; next_d[0] = 1'b1;
      @(posedge clk); #1; in_d[0] = 1'b1;
      @(posedge clk); #1; in_d[0] = 1'b0;
      @(posedge clk); #1; next_d[0] = 1'b0;
      chk("t5_out", ifa.out, 1); chk("t5_cnt", ifa.match_cnt, 3); chk("t5_fill", ifa.fill, 3);
      pulse_reset();
      chk("t5_rst_out", ifa.out, 0); chk("t5_rst_cnt", ifa.match_cnt, 0);
      chk("t5_rst_fill", ifa.fill, 0); chk("t5_rst_st", ifa.state_display, 0);
      chk("t5_rst_clock", ifc.locked, 0); chk("t5_rst_ccnt", ifc.match_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
Parametrised successor to the single-pattern serial sequence-detector FSM. Serial bits are stepped in with a `next` strobe. The block compares a sliding window of the last PAT_LEN accepted bits against a programmable match pattern and a programmable lock pattern. It adds overlap/non-overlap modes, a sticky lock state with explicit release, a saturating match counter and a window fill indicator. It sits between debounced board inputs (switch/button) and the display/LED logic.

Parameters:
PAT_LEN, 3, window and pattern length in bits (2..8)
MATCH_PAT, 3'b010, pattern that asserts out; bit [PAT_LEN-1] is the oldest bit
LOCK_PAT, 3'b111, pattern that forces the LOCKED state
OVERLAP, 1, 1 = sliding overlapped detection; 0 = window restarts after each match
CNT_W, 8, width of match counter

Ports:
clk  in  1  system clock, all logic on posedge
reset_n  in  1  synchronous reset, active-low
in  in  1  serial data bit
next  in  1  step strobe; bit `in` accepted on a posedge where next=1
clear_lock  in  1  releases LOCKED state, clears window
state_display  out  2  current state: 0 IDLE, 1 FILL, 2 RUN, 3 LOCKED
fill  out  $clog2(PAT_LEN+1)  number of valid bits in window
out  out  1  match level
match_cnt  out  CNT_W  number of matches since reset, saturating
locked  out  1  high in LOCKED

Behaviour:
- Reset: reset_n=0 at posedge -> state IDLE, window 0, fill 0, out 0, match_cnt 0, locked 0. Reset has priority over every other input.
- Acceptance: at a posedge with next=1 and state!=LOCKED, the window shifts left and `in` enters the LSB. fill increments, saturating at PAT_LEN. One bit is accepted per cycle while next is held high.
- next=0: all state holds.
- Registered outputs: all outputs are registered and update at the same posedge the bit is accepted.
- States:
  - IDLE: fill=0. Accepting a bit -> FILL, or RUN if PAT_LEN reached.
  - FILL: 0<fill<PAT_LEN. Goes to RUN when fill reaches PAT_LEN.
  - RUN: window full; evaluation runs on every accepted bit.
  - LOCKED: next ignored; out 0; fill and window frozen.
- Evaluation uses the post-shift window, only when fill==PAT_LEN:
  - Window==LOCK_PAT -> LOCKED, locked=1, out=0. Lock has priority if LOCK_PAT==MATCH_PAT.
  - Else window==MATCH_PAT -> out=1 and match_cnt+1, saturating at all-ones.
  - Else out=0.
- out timing: Moore-like level; out stays high until the next accepted bit, reset or clear_lock.
- OVERLAP=0: the first bit accepted after a match (out=1) starts a fresh window. Window={0..,in}, fill=1, state FILL, out=0. Overlapped windows therefore never match.
- OVERLAP=1: the window slides normally; overlapping matches count.
- clear_lock=1 at a posedge: state IDLE, window 0, fill 0, out 0, locked 0. match_cnt is retained.
  - Effective in any state, not only LOCKED.
  - If next=1 in the same cycle, clear_lock wins and the bit is discarded.
- Reset mid-sequence discards partial window and counter.
- Width rule: MATCH_PAT/LOCK_PAT are compared on bits [PAT_LEN-1:0] only.

Test Plan:
1. Defaults, after reset: steps 0,1,0 -> fill 1,2,3; state 1,1,2; out=1 after third step; match_cnt=1.
2. Defaults, continuing: steps 0,1,1 -> out 0 each step, no lock (window 011). Step 1 -> window 111: locked=1, state=3, out=0. Further steps 0,1 -> no change, fill stays 3.
3. From LOCKED, clear_lock=1 with next=1, in=0 -> state 0, fill 0, bit discarded. match_cnt still 1. Then 0,1,0 -> out=1, match_cnt=2.
4. Overlap:
   - OVERLAP=1, steps 0,1,0,1,0 -> out high after steps 3 and 5; match_cnt=2.
   - OVERLAP=0, same stimulus -> out high after step 3 only; fill=1 after step 4; match_cnt=1.
5. Holding next=1 for 3 cycles with in=0,1,0 -> three bits accepted, out=1. Assert reset_n=0 for one cycle mid-sequence -> all outputs 0 next cycle.
6. CNT_W=2, OVERLAP=1, PAT_LEN=2, MATCH_PAT=2'b11, LOCK_PAT=2'b00:
   - Steps 1,1,1,1,1 -> match_cnt 0,1,2,3,3 (saturates).
   - Then step 0, 0 -> LOCKED.
